// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divider time-sharing scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int WIDTH_DEF   = 16;
    localparam int N_REQ_DEF   = 3;
    localparam int TIMEOUT_DEF = 64;
    localparam int ID_W        = $clog2(N_REQ_DEF);

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Requester and divider signals of the shared-divider scheduler.
interface div_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 3
);
    // req_valid[i] with stable operands until req_ready[i] (one-cycle pulse);
    // resp_valid[i] is a one-cycle pulse with resp_quotient/resp_overflow;
    // div_start is a one-cycle pulse, div_complete is honoured only while waiting.
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][WIDTH-1:0] req_dividend;
    logic [N_REQ-1:0][WIDTH-1:0] req_divisor;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            resp_valid;
    logic [WIDTH-1:0]            resp_quotient;
    logic                        resp_overflow;
    logic                        div_start;
    logic [WIDTH-1:0]            div_dividend;
    logic [WIDTH-1:0]            div_divisor;
    logic                        div_complete;
    logic [WIDTH-1:0]            div_quotient;
    logic                        div_overflow;

    modport master (
        input  req_valid, req_dividend, req_divisor,
        input  div_complete, div_quotient, div_overflow,
        output req_ready, resp_valid, resp_quotient, resp_overflow,
        output div_start, div_dividend, div_divisor
    );

    modport slave (
        output req_valid, req_dividend, req_divisor,
        output div_complete, div_quotient, div_overflow,
        input  req_ready, resp_valid, resp_quotient, resp_overflow,
        input  div_start, div_dividend, div_divisor
    );

endinterface

// File: rtl/div_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid request at or after ptr, with wrap.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        k       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one external fixed-point divider among N_REQ requesters, round-robin,
// with local divide-by-zero and timeout handling.
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    div_scheduler_if.master bus,
    output logic            busy
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic               ovf_q, ovf_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [N_REQ-1:0]   req_ready_c;
    logic [N_REQ-1:0]   resp_valid_c;
    logic               div_start_c;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign timer_inc = timer_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_idx_d    = gnt_idx_q;
        timer_d      = timer_q;
        dvd_d        = dvd_q;
        dvs_d        = dvs_q;
        quot_d       = quot_q;
        ovf_d        = ovf_q;
        req_ready_c  = '0;
        resp_valid_c = '0;
        div_start_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_c = arb_gnt;
                    gnt_idx_d   = arb_idx;
                    dvd_d       = bus.req_dividend[arb_idx];
                    dvs_d       = bus.req_divisor[arb_idx];
                    // A zero divisor is answered locally; the divider never sees it.
                    if (bus.req_divisor[arb_idx] == '0) begin
                        quot_d  = '0;
                        ovf_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_start_c = 1'b1;
                timer_d     = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                timer_d = timer_inc;
                if (bus.div_complete) begin
                    quot_d  = bus.div_quotient;
                    ovf_d   = bus.div_overflow;
                    state_d = RESP;
                end else if (timer_inc == TMR_LAST) begin
                    // Timer counts this cycle, so the response lands TIMEOUT cycles after start.
                    quot_d  = '0;
                    ovf_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_c[gnt_idx_q] = 1'b1;
                rr_ptr_d = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            timer_q   <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quot_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            timer_q   <= timer_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quot_q    <= quot_d;
            ovf_q     <= ovf_d;
        end
    end

    // The grant is combinational from req_valid, so it is held off while reset is asserted.
    assign bus.req_ready     = rst ? '0 : req_ready_c;
    assign bus.resp_valid    = resp_valid_c;
    assign bus.resp_quotient = quot_q;
    assign bus.resp_overflow = ovf_q;
    assign bus.div_start     = div_start_c;
    assign bus.div_dividend  = dvd_q;
    assign bus.div_divisor   = dvs_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler with a Q8.8 divider model on the div_* side.
module tb_div_scheduler;

  logic clk;
  logic rst;
  logic busy;

  div_scheduler_if #(.WIDTH(16), .N_REQ(3)) bus ();

  div_scheduler #(.WIDTH(16), .N_REQ(3), .TIMEOUT(64)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int ready_cyc[3];
  int ready_cnt[3];
  int req_left[3];
  int start_cnt;
  int start_cyc;
  int resp_cnt;
  int resp_cyc;
  int div_cnt;
  int div_lat;
  bit div_hang;
  bit div_ovf_mode;
  logic [2:0] ready_seen;
  logic start_seen;
  logic [19:0] exp_q[$];
  logic [2:0] exp_gnt_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then update requesters and divider model after posedge.
  task automatic step();
    logic [19:0] e;
    logic [2:0] g;
    int a;
    int b;
    @(negedge clk);
    ready_seen = bus.req_ready;
    start_seen = bus.div_start;
    if (bus.req_ready != 3'b000) begin
      g = (exp_gnt_q.size() != 0) ? exp_gnt_q.pop_front() : 3'b000;
      chk("grant", {29'd0, bus.req_ready}, {29'd0, g});
      for (int i = 0; i < 3; i++) begin
        if (bus.req_ready[i]) begin
          ready_cnt[i]++;
          ready_cyc[i] = cyc;
        end
      end
    end
    if (bus.div_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (bus.resp_valid != 3'b000) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 20'h0;
      chk("resp", {12'd0, bus.resp_valid, bus.resp_quotient, bus.resp_overflow}, {12'd0, e});
      resp_cnt++;
      resp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (ready_seen[i]) begin
        if (req_left[i] > 0) req_left[i]--;
        if (req_left[i] == 0) bus.req_valid[i] = 1'b0;
      end
    end
    bus.div_complete = 1'b0;
    if (div_cnt > 0) begin
      div_cnt--;
      if (div_cnt == 0) begin
        bus.div_complete = 1'b1;
        if (div_ovf_mode) begin
          bus.div_quotient = 16'h7FFF;
          bus.div_overflow = 1'b1;
        end else begin
          a = int'($signed(bus.div_dividend));
          b = int'($signed(bus.div_divisor));
          bus.div_quotient = 16'((a * 256) / b);
          bus.div_overflow = 1'b0;
        end
      end
    end
    if (start_seen && !div_hang) div_cnt = div_lat;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((busy || bus.req_valid != 3'b000 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("run_bound", {31'd0, (n < budget)}, 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, {29'd0, bus.req_ready}, 32'd0);
    chk({tag, "_resp_valid"}, {29'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_resp_quotient"}, {16'd0, bus.resp_quotient}, 32'd0);
    chk({tag, "_resp_overflow"}, {31'd0, bus.resp_overflow}, 32'd0);
    chk({tag, "_div_start"}, {31'd0, bus.div_start}, 32'd0);
    chk({tag, "_div_dividend"}, {16'd0, bus.div_dividend}, 32'd0);
    chk({tag, "_div_divisor"}, {16'd0, bus.div_divisor}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int s0;
    int r0;
    int n;
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    cyc = 0;
    start_cnt = 0;
    resp_cnt = 0;
    div_cnt = 0;
    div_lat = 17;
    div_hang = 1'b0;
    div_ovf_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ready_cyc[i] = 0;
      ready_cnt[i] = 0;
      req_left[i] = 0;
    end
    bus.div_complete = 1'b0;
    bus.div_quotient = 16'h0;
    bus.div_overflow = 1'b0;
    // Three requesters pending while reset holds: nothing may be granted.
    bus.req_dividend[0] = 16'h0300; bus.req_divisor[0] = 16'h0100;
    bus.req_dividend[1] = 16'hFC00; bus.req_divisor[1] = 16'h0200;
    bus.req_dividend[2] = 16'h0100; bus.req_divisor[2] = 16'hFE00;
    bus.req_valid = 3'b111;
    step();
    step();
    chk_outputs_zero("reset");

    // Fairness: two ops each, requester stays valid across its own response.
    req_left[0] = 2; req_left[1] = 2; req_left[2] = 2;
    for (int r = 0; r < 2; r++) begin
      exp_gnt_q.push_back(3'b001); exp_q.push_back({3'b001, 16'h0300, 1'b0});
      exp_gnt_q.push_back(3'b010); exp_q.push_back({3'b010, 16'hFE00, 1'b0});
      exp_gnt_q.push_back(3'b100); exp_q.push_back({3'b100, 16'hFF80, 1'b0});
    end
    rst = 1'b0;
    run(400);
    req_left[0] = 1; req_left[2] = 1;
    bus.req_valid = 3'b101;
    exp_gnt_q.push_back(3'b001); exp_q.push_back({3'b001, 16'h0300, 1'b0});
    exp_gnt_q.push_back(3'b100); exp_q.push_back({3'b100, 16'hFF80, 1'b0});
    run(200);
    chk("ready_cnt0", ready_cnt[0], 3);
    chk("ready_cnt1", ready_cnt[1], 2);
    chk("ready_cnt2", ready_cnt[2], 3);

    // Single request, 2.0 / 1.0.
    s0 = start_cnt;
    r0 = ready_cnt[0];
    req_left[0] = 1;
    bus.req_dividend[0] = 16'h0200; bus.req_divisor[0] = 16'h0100;
    bus.req_valid = 3'b001;
    exp_gnt_q.push_back(3'b001); exp_q.push_back({3'b001, 16'h0200, 1'b0});
    run(100);
    chk("single_latency", resp_cyc - ready_cyc[0], 20);
    chk("single_starts", start_cnt - s0, 1);
    chk("single_ready_pulses", ready_cnt[0] - r0, 1);

    // Divide by zero on requester 1.
    s0 = start_cnt;
    req_left[1] = 1;
    bus.req_dividend[1] = 16'h1234; bus.req_divisor[1] = 16'h0000;
    bus.req_valid = 3'b010;
    exp_gnt_q.push_back(3'b010); exp_q.push_back({3'b010, 16'h0000, 1'b1});
    run(20);
    chk("div0_latency", resp_cyc - ready_cyc[1], 1);
    chk("div0_no_start", start_cnt - s0, 0);

    // Divider overflow passed through.
    div_ovf_mode = 1'b1;
    req_left[2] = 1;
    bus.req_dividend[2] = 16'h7000; bus.req_divisor[2] = 16'h0010;
    bus.req_valid = 3'b100;
    exp_gnt_q.push_back(3'b100); exp_q.push_back({3'b100, 16'h7FFF, 1'b1});
    run(100);
    div_ovf_mode = 1'b0;

    // Timeout: divider never completes.
    div_hang = 1'b1;
    req_left[0] = 1;
    bus.req_dividend[0] = 16'h0100; bus.req_divisor[0] = 16'h0100;
    bus.req_valid = 3'b001;
    exp_gnt_q.push_back(3'b001); exp_q.push_back({3'b001, 16'h0000, 1'b1});
    run(200);
    chk("timeout_latency", resp_cyc - start_cyc, 64);
    r0 = resp_cnt;
    s0 = start_cnt;
    bus.div_complete = 1'b1;
    bus.div_quotient = 16'h1234;
    bus.div_overflow = 1'b0;
    step();
    step();
    step();
    chk("late_complete_no_resp", resp_cnt - r0, 0);
    chk("late_complete_no_start", start_cnt - s0, 0);
    chk("late_complete_idle", {31'd0, busy}, 32'd0);
    div_hang = 1'b0;

    // Async reset in the middle of a wait: the operation is dropped silently.
    req_left[1] = 1;
    bus.req_dividend[1] = 16'h0400; bus.req_divisor[1] = 16'h0200;
    bus.req_valid = 3'b010;
    exp_gnt_q.push_back(3'b010);
    s0 = start_cnt;
    n = 0;
    while (start_cnt == s0 && n < 10) begin
      step();
      n++;
    end
    chk("reset_case_started", start_cnt - s0, 1);
    for (int i = 0; i < 5; i++) step();
    chk("reset_case_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("async_reset");
    div_cnt = 0;
    r0 = resp_cnt;
    step();
    step();
    step();
    rst = 1'b0;
    chk("async_reset_no_resp", resp_cnt - r0, 0);

    // After reset the pointer is back at requester 0.
    req_left[0] = 1; req_left[1] = 1;
    bus.req_dividend[0] = 16'h0100; bus.req_divisor[0] = 16'h0100;
    bus.req_dividend[1] = 16'hFF00; bus.req_divisor[1] = 16'h0100;
    bus.req_valid = 3'b011;
    exp_gnt_q.push_back(3'b001); exp_q.push_back({3'b001, 16'h0100, 1'b0});
    exp_gnt_q.push_back(3'b010); exp_q.push_back({3'b010, 16'hFF00, 1'b0});
    run(200);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_gnt_q_drained", exp_gnt_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
